// File: rtl/fish_motion_ctrl.sv
// Per-fish motion engine: spawns a fish on a rising appear edge, moves it
// `speed` pixels per motion tick until it leaves the screen, and tracks the hook while hooked.
module fish_motion_ctrl #(
  parameter int TICK_DIV = 2000000,
  parameter int H_RES    = 640,
  parameter int V_RES    = 480,
  parameter int POS_W    = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             appear,
  input  logic [1:0]       way,
  input  logic [2:0]       speed,
  input  logic [POS_W-1:0] start_h,
  input  logic [POS_W-1:0] start_v,
  input  logic             hooked,
  input  logic [POS_W-1:0] hook_v,
  output logic [POS_W-1:0] fish_h,
  output logic [POS_W-1:0] fish_v,
  output logic             active,
  output logic             step,
  output logic             exited
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);
  localparam logic [POS_W:0]   H_LIM   = (POS_W+1)'(H_RES);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SWIM   = 2'd1;
  localparam logic [1:0] HOOKED = 2'd2;

  if (TICK_DIV < 2 || H_RES > (1 << POS_W) || V_RES > (1 << POS_W)) begin : g_bad_param
    $error("fish_motion_ctrl: illegal parameter combination");
  end

  logic [1:0]       state, state_n;
  logic             appear_d;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [1:0]       way_q;
  logic [2:0]       speed_q;
  logic [POS_W-1:0] h_n, v_n;
  logic             exit_n;
  logic             launch;
  logic             tick_due;
  logic [POS_W:0]   h_ext, v_ext, spd_ext;

  assign launch   = appear & ~appear_d;
  assign tick_due = (cnt == CNT_MAX);
  assign h_ext    = {1'b0, fish_h};
  assign v_ext    = {1'b0, fish_v};
  assign spd_ext  = (POS_W+1)'(speed_q);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    h_n     = fish_h;
    v_n     = fish_v;
    exit_n  = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (launch) begin
          h_n     = start_h;
          v_n     = start_v;
          state_n = SWIM;
        end
      end
      SWIM, HOOKED: begin
        // Removal beats hooking, and hooking swallows any step due this cycle.
        if (!appear) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (hooked) begin
          state_n = HOOKED;
          v_n     = hook_v;
        end else if (state == HOOKED) begin
          state_n = SWIM;
          cnt_n   = '0;
        end else begin
          cnt_n = tick_due ? '0 : cnt + 1'b1;
          if (tick_due && speed_q != 3'd0) begin
            case (way_q)
              2'd0: begin
                if (h_ext < spd_ext) exit_n = 1'b1;
                else                 h_n = fish_h - POS_W'(speed_q);
              end
              2'd1: begin
                if ((h_ext + spd_ext) >= H_LIM) exit_n = 1'b1;
                else                            h_n = fish_h + POS_W'(speed_q);
              end
              2'd2: begin
                if (v_ext < spd_ext) exit_n = 1'b1;
                else                 v_n = fish_v - POS_W'(speed_q);
              end
              default: ;
            endcase
          end
          if (exit_n) begin
            state_n = IDLE;
            cnt_n   = '0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      appear_d <= 1'b0;
      cnt      <= '0;
      way_q    <= 2'd0;
      speed_q  <= 3'd0;
      fish_h   <= '0;
      fish_v   <= '0;
      active   <= 1'b0;
      step     <= 1'b0;
      exited   <= 1'b0;
    end else begin
      appear_d <= appear;
      state    <= state_n;
      cnt      <= cnt_n;
      fish_h   <= h_n;
      fish_v   <= v_n;
      if (state == IDLE && launch) begin
        way_q   <= way;
        speed_q <= speed;
      end
      // step is raised for the whole cycle in which the tick is due.
      active <= (state_n != IDLE);
      step   <= (state_n == SWIM) && (cnt_n == CNT_MAX);
      exited <= exit_n;
    end
  end

endmodule

// File: tb/tb_fish_motion_ctrl.sv
// Scoreboard bench for fish_motion_ctrl: directed scenarios then random stimulus,
// expected outputs from a cycle-level behavioural model of the fish.
module tb_fish_motion_ctrl;

  localparam int TD    = 4;
  localparam int HRES  = 640;
  localparam int VRES  = 480;
  localparam int PW    = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          appear = 1'b0;
  logic [1:0]    way = 2'd0;
  logic [2:0]    speed = 3'd0;
  logic [PW-1:0] start_h = '0;
  logic [PW-1:0] start_v = '0;
  logic          hooked = 1'b0;
  logic [PW-1:0] hook_v = '0;
  logic [PW-1:0] fish_h, fish_v;
  logic          active, step, exited;

  fish_motion_ctrl #(.TICK_DIV(TD), .H_RES(HRES), .V_RES(VRES), .POS_W(PW)) dut (
    .clk(clk), .rst(rst), .appear(appear), .way(way), .speed(speed),
    .start_h(start_h), .start_v(start_v), .hooked(hooked), .hook_v(hook_v),
    .fish_h(fish_h), .fish_v(fish_v), .active(active), .step(step), .exited(exited)
  );

  always #5 clk = ~clk;

  typedef struct {
    int h;
    int v;
    int act;
    int stp;
    int ext;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_pass = 0;

  // model of the fish
  int m_alive, m_hk, m_h, m_v, m_age, m_way, m_speed, m_prev_appear;
  int m_step, m_exit;

  task automatic chk(input string name, input int act, input int want);
    n_chk++;
    if (act == want) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
  endtask

  task automatic model_reset();
    m_alive = 0; m_hk = 0; m_h = 0; m_v = 0; m_age = 0;
    m_way = 0; m_speed = 0; m_prev_appear = 0; m_step = 0; m_exit = 0;
  endtask

  task automatic model_edge();
    int launch, nh, nv, out;
    launch = appear && !m_prev_appear;
    m_prev_appear = appear;
    m_exit = 0;
    if (!m_alive) begin
      if (launch) begin
        m_alive = 1; m_hk = 0; m_age = 0;
        m_h = start_h; m_v = start_v; m_way = way; m_speed = speed;
      end
    end else if (!appear) begin
      m_alive = 0; m_hk = 0;
    end else if (hooked) begin
      m_hk = 1; m_v = hook_v;
    end else if (m_hk) begin
      m_hk = 0; m_age = 0;
    end else begin
      if ((m_age % TD) == TD - 1 && m_speed != 0) begin
        nh = m_h; nv = m_v; out = 0;
        case (m_way)
          0: begin nh = m_h - m_speed; out = (nh < 0); end
          1: begin nh = m_h + m_speed; out = (nh >= HRES); end
          2: begin nv = m_v - m_speed; out = (nv < 0); end
          default: ;
        endcase
        if (out) begin
          m_alive = 0; m_exit = 1;
        end else begin
          m_h = nh; m_v = nv;
        end
      end
      m_age++;
    end
    m_step = m_alive && !m_hk && ((m_age % TD) == TD - 1);
  endtask

  // Inputs are already set (at a falling edge); predict the next rising edge.
  task automatic cycle();
    exp_t e;
    model_edge();
    e.h = m_h; e.v = m_v; e.act = m_alive; e.stp = m_step; e.ext = m_exit;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_fish_h"}, fish_h, 0);
    chk({tag, "_fish_v"}, fish_v, 0);
    chk({tag, "_active"}, active, 0);
    chk({tag, "_step"},   step, 0);
    chk({tag, "_exited"}, exited, 0);
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("fish_h", fish_h, e.h);
      chk("fish_v", fish_v, e.v);
      chk("active", active, e.act);
      chk("step",   step,   e.stp);
      chk("exited", exited, e.ext);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d checks done", n_chk);
    $fatal(1);
  end

  initial begin
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    // rightward swim from 100
    start_h = 100; start_v = 200; way = 2'd1; speed = 3'd3; appear = 1'b1;
    cycle();
    for (int i = 0; i < 14; i++) begin
      start_h = PW'($urandom_range(0, 639)); way = 2'($urandom_range(0, 3));
      speed = 3'($urandom_range(0, 7));
      cycle();
    end

    // leftward exit at the left edge, no relaunch while appear stays high
    appear = 1'b0; cycle();
    start_h = 7; start_v = 40; way = 2'd0; speed = 3'd5; appear = 1'b1;
    for (int i = 0; i < 16; i++) cycle();

    // rightward exit at the right edge
    appear = 1'b0; cycle();
    start_h = 630; start_v = 10; way = 2'd1; speed = 3'd7; appear = 1'b1;
    for (int i = 0; i < 12; i++) cycle();

    // hooked tracking, then release
    appear = 1'b0; cycle();
    start_h = 300; start_v = 100; way = 2'd1; speed = 3'd1; appear = 1'b1;
    for (int i = 0; i < 5; i++) cycle();
    hooked = 1'b1;
    hook_v = 50; cycle(); cycle();
    hook_v = 60; cycle(); cycle();
    hook_v = 70; cycle(); cycle();
    hooked = 1'b0;
    for (int i = 0; i < 10; i++) cycle();

    // remove and hook in the same cycle a step is due
    for (int k = 0; k < 10 && !m_step; k++) cycle();
    appear = 1'b0; hooked = 1'b1; cycle();
    hooked = 1'b0; cycle(); cycle();

    // asynchronous reset mid-swim, appear held high through release
    start_h = 321; start_v = 123; way = 2'd2; speed = 3'd2; appear = 1'b1;
    for (int i = 0; i < 6; i++) cycle();
    #2 rst = 1'b1;
    #1 check_zero("async_rst");
    @(posedge clk);
    #1 check_zero("rst_held");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 10; i++) cycle();

    // random stimulus
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) appear = ~appear;
      if ($urandom_range(0, 29) == 0) hooked = ~hooked;
      hook_v  = PW'($urandom_range(0, 479));
      way     = 2'($urandom_range(0, 3));
      speed   = 3'($urandom_range(0, 7));
      start_h = $urandom_range(0, 1) ? PW'($urandom_range(0, 20)) : PW'($urandom_range(610, 639));
      start_v = PW'($urandom_range(0, 40));
      cycle();
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fish_motion_ctrl.md
Name: fish_motion_ctrl

Overview:
Per-fish motion engine for the fishing game. It spawns a fish at a given start position when told to appear. The fish then moves a programmable number of pixels per motion tick in a chosen direction until it leaves the visible area. While hooked, its vertical position tracks the hook. One instance per fish; the outputs feed the sprite/pixel-compare logic in the VGA path.

Parameters:
TICK_DIV, 2000000, clock cycles per motion step (>=2)
H_RES, 640, visible horizontal pixels
V_RES, 480, visible vertical pixels
POS_W, 10, position width in bits

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
appear  input  1  level; rising edge launches a fish; low removes it
way  input  2  0=left, 1=right, 2=up, 3=hold (no motion)
speed  input  3  pixels moved per step (0..7)
start_h  input  POS_W  spawn horizontal position
start_v  input  POS_W  spawn vertical position
hooked  input  1  level; fish is on the hook
hook_v  input  POS_W  hook vertical position
fish_h  output  POS_W  current horizontal position
fish_v  output  POS_W  current vertical position
active  output  1  fish exists (state SWIM or HOOKED)
step  output  1  one-cycle pulse on each motion tick in SWIM
exited  output  1  one-cycle pulse when fish leaves the screen

Behaviour:
- One clock, clk. Reset is asynchronous and active-high on rst.
- Reset values: state=IDLE, fish_h=0, fish_v=0, active=0, step=0, exited=0, tick counter=0, appear_d=0, latched way/speed=0.
- launch = appear & ~appear_d; appear_d is appear registered every cycle. A fish relaunches only after appear has gone low and then high again.
- IDLE:
  - active=0; counter held at 0.
  - On launch, the next edge loads fish_h=start_h and fish_v=start_v, latches way and speed, clears the counter and enters SWIM.
- SWIM:
  - Counter runs 0..TICK_DIV-1, then wraps to 0.
  - In the cycle the counter equals TICK_DIV-1, step=1 and the move is applied on that edge.
  - left: if fish_h < speed, exit; else fish_h -= speed.
  - right: if fish_h+speed >= H_RES, exit; else fish_h += speed.
  - up: if fish_v < speed, exit; else fish_v -= speed.
  - hold, or speed=0: no position change and never exits.
  - Boundary compares use POS_W+1 bits; the position register never wraps.
  - Exit: exited=1 for one cycle (registered, coincident with the state returning to IDLE). The position freezes at its last value.
- HOOKED:
  - fish_v <= hook_v every cycle (1-cycle latency); fish_h frozen; counter frozen; step=0.
  - When hooked falls, the state returns to SWIM with the counter cleared to 0.
- Priority in SWIM/HOOKED, highest first:
  - appear=0: go to IDLE with no exited pulse.
  - hooked=1: go to or stay in HOOKED. A step due in the same cycle is discarded.
  - Step/exit processing.
- way, speed, start_h and start_v changes after launch are ignored until the next launch.
- Reset mid-operation returns everything to reset values immediately. If appear is still high when rst releases, the fish launches (appear_d=0).
- step and exited are registered outputs, never combinational glitches.

Test Plan:
- TICK_DIV=4; appear rises with start_h=100, start_v=200, way=1, speed=3 -> one edge later active=1, fish_h=100; step pulses every 4 cycles; fish_h=103, 106, ...
- way=0, speed=5, start_h=7 -> after step 1, fish_h=2; at step 2 exited pulses once, active=0, fish_h stays 2; no relaunch while appear stays high.
- way=1, speed=7, start_h=630 -> first step gives 637; second step (644>=640) exits with exited=1 for exactly one cycle.
- In SWIM assert hooked with hook_v sweeping 50, 60, 70 -> fish_v follows with 1-cycle lag, fish_h constant, no step; release hooked -> next step exactly TICK_DIV cycles later.
- Drop appear in the same cycle as a due step and as hooked -> IDLE next edge, exited=0, position unchanged.
- Assert rst mid-SWIM asynchronously (between edges) -> outputs zero immediately; hold appear high through release -> relaunch at start_h/start_v on the first post-reset edge.
